// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns the PC, fetches over req/ack, waits on ex_done.
// Optional MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        pc_src,
  input  logic [31:0] new_pc,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        trap,
  output logic [31:0] trap_addr
`endif
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
`ifdef MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
`ifdef MISALIGN_TRAP_EN
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
`endif
    unique case (state_q)
      S_HOLD: begin
        if (!stall)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ex_done) begin
          instret_d = instret_q + 32'd1;
          if (pc_src)
            pc_d = new_pc & ~32'd3;
          else
            pc_d = pc_q + 32'd4;
`ifdef MISALIGN_TRAP_EN
          if (pc_src && (new_pc[1:0] != 2'b00)) begin
            pc_d        = TRAP_VECTOR;
            trap_d      = 1'b1;
            trap_addr_d = new_pc;
          end
`endif
          if (halt)
            state_d = S_HALTED;
          else if (stall)
            state_d = S_HOLD;
          else
            state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HOLD;
      pc_q      <= RESET_VECTOR;
      instr_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q      <= 1'b0;
      trap_addr_q <= 32'd0;
    end else begin
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign trap      = trap_q;
  assign trap_addr = trap_addr_q;
`endif

  // Handshake outputs decode from state alone; no input reaches an output.
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALTED);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: phase-level reference model plus directed vectors.
// Build with or without MISALIGN_TRAP_EN.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic        pc_src;
  logic [31:0] new_pc;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halted;
`ifdef MISALIGN_TRAP_EN
  logic        trap;
  logic [31:0] trap_addr;
`endif

  logic        rd_mode;
  int          n_cmp;
  int          n_bad;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .ex_done     (ex_done),
    .pc_src      (pc_src),
    .new_pc      (new_pc),
    .halt        (halt),
    .pc          (pc),
    .instret     (instret),
    .halted      (halted)
`ifdef MISALIGN_TRAP_EN
    ,
    .trap        (trap),
    .trap_addr   (trap_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns either a fixed nop or an address-tagged word.
  always_comb
    imem_rdata = rd_mode ? {imem_addr[29:0], 2'b11} : 32'h0000_0013;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 fetching, 2 executing, 3 stopped.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;
  logic        m_trap;
  logic [31:0] m_taddr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_ret   = 32'h0;
      m_trap  = 1'b0;
      m_taddr = 32'h0;
    end else begin
      m_trap = 1'b0;
      if (m_phase == 0) begin
        if (!stall) m_phase = 1;
      end else if (m_phase == 1) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (ex_done) begin
          m_ret = m_ret + 1;
          if (!pc_src) begin
            m_pc = m_pc + 4;
          end else begin
`ifdef MISALIGN_TRAP_EN
            if (new_pc % 4 != 0) begin
              m_pc    = 32'h100;
              m_trap  = 1'b1;
              m_taddr = new_pc;
            end else begin
              m_pc = new_pc;
            end
`else
            m_pc = new_pc - (new_pc % 4);
`endif
          end
          m_phase = halt ? 3 : (stall ? 0 : 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_pc", pc, m_pc);
      chk("m_addr", imem_addr, m_pc);
      chk("m_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
      chk("m_valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
      chk("m_halted", {31'd0, halted}, {31'd0, m_phase == 3});
      chk("m_instret", instret, m_ret);
      chk("m_instr", instr, m_instr);
`ifdef MISALIGN_TRAP_EN
      chk("m_trap", {31'd0, trap}, {31'd0, m_trap});
      chk("m_taddr", trap_addr, m_taddr);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int req_seen;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    stall   = 1'b0;
    imem_ack = 1'b1;
    ex_done = 1'b1;
    pc_src  = 1'b0;
    new_pc  = 32'h0;
    halt    = 1'b0;
    rd_mode = 1'b0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ret", instret, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait streaming, 1 instruction per 2 cycles.
    tick(1);
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    tick(1);
    chk("t1_instr", instr, 32'h13);
    tick(7);
    chk("t1_pc", pc, 32'h10);
    chk("t1_ret", instret, 32'd4);

    // Redirect then fall through.
    pc_src = 1'b1;
    new_pc = 32'h40;
    tick(2);
    chk("t2_addr", imem_addr, 32'h40);
    pc_src = 1'b0;
    tick(2);
    chk("t2_addr2", imem_addr, 32'h44);

    // Three-cycle memory latency.
    rd_mode  = 1'b1;
    imem_ack = 1'b0;
    tick(2);
    chk("t3_req", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h44);
    chk("t3_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    tick(1);
    chk("t3_valid1", {31'd0, instr_valid}, 32'd1);
    chk("t3_instr", instr, 32'h113);

    // Stall at retirement parks in idle.
    stall = 1'b1;
    tick(1);
    chk("t4_pc", pc, 32'h48);
    tick(3);
    chk("t4_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick(1);
    chk("t4_req1", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h48);

    // Halt at 0x20.
    pc_src = 1'b1;
    new_pc = 32'h20;
    tick(2);
    chk("t5_pc20", pc, 32'h20);
    pc_src = 1'b0;
    halt   = 1'b1;
    tick(2);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_pc", pc, 32'h24);
    chk("t5_ret", instret, 32'd9);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (imem_req) req_seen++;
    end
    chk("t5_noreq", req_seen, 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_pc", pc, 32'h0);
    chk("t5_rst_halt", {31'd0, halted}, 32'd0);
    halt   = 1'b0;
    pc_src = 1'b1;
    new_pc = 32'h42;
    tick(1);
    rst = 1'b0;

    // Misaligned redirect.
    tick(3);
`ifdef MISALIGN_TRAP_EN
    chk("t6_pc", pc, 32'h100);
    chk("t6_trap", {31'd0, trap}, 32'd1);
    chk("t6_taddr", trap_addr, 32'h42);
`else
    chk("t6_pc", pc, 32'h40);
`endif
    chk("t6_ret", instret, 32'd1);
    pc_src   = 1'b0;
    imem_ack = 1'b0;
    tick(1);
`ifdef MISALIGN_TRAP_EN
    chk("t6_trap0", {31'd0, trap}, 32'd0);
    chk("t6_taddr1", trap_addr, 32'h42);
`endif
    chk("t6_req", {31'd0, imem_req}, 32'd1);

    // Reset while a fetch is outstanding; late ack is dropped.
    rst = 1'b1;
    #1;
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("t6_rst_pc", pc, 32'h0);
    imem_ack = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_late_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_late_instr", instr, 32'h0);
    tick(1);
    chk("t6_refetch", {31'd0, imem_req}, 32'd1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
